// File: rtl/fetch_unit_if.sv
// Instruction-memory and decoder-facing bus of the fetch unit.
// master = fetch unit side, slave = memory/decoder side.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16
);
  localparam int unsigned PAYLOAD_W = INSTR_W - 5;

  logic                 imem_req;
  logic [ADDR_W-1:0]    imem_addr;
  logic                 imem_ack;
  logic [INSTR_W-1:0]   imem_rdata;
  logic [4:0]           opcode;
  logic [PAYLOAD_W-1:0] payload;
  logic                 instr_valid;
  logic                 instr_ready;
  logic                 branch_en;
  logic [ADDR_W-1:0]    branch_target;

  modport master (
    output imem_req, imem_addr, opcode, payload, instr_valid,
    input  imem_ack, imem_rdata, instr_ready, branch_en, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, opcode, payload, instr_valid,
    output imem_ack, imem_rdata, instr_ready, branch_en, branch_target
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: fetches from imem at pc, issues opcode/payload to the
// decoder, advances or branches on handshake, halts on HALT_OP or memory timeout.
module fetch_unit #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned TIMEOUT = 16,
  parameter logic [4:0]  HALT_OP = 5'b11111
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  fetch_unit_if.master      bus,
  output logic [ADDR_W-1:0] pc_o,
  output logic              halted_o,
  output logic              fetch_err_o
);
  localparam int unsigned PAYLOAD_W = INSTR_W - 5;
  localparam int unsigned CNT_W     = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  logic [1:0]           state_q,     state_d;
  logic [ADDR_W-1:0]    pc_q,        pc_d;
  logic                 imem_req_q,  imem_req_d;
  logic                 valid_q,     valid_d;
  logic [4:0]           opcode_q,    opcode_d;
  logic [PAYLOAD_W-1:0] payload_q,   payload_d;
  logic                 halted_q,    halted_d;
  logic                 fetch_err_q, fetch_err_d;
  logic [CNT_W-1:0]     tmo_q,       tmo_d;

  // State and registered outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      imem_req_q  <= 1'b0;
      valid_q     <= 1'b0;
      opcode_q    <= '0;
      payload_q   <= '0;
      halted_q    <= 1'b0;
      fetch_err_q <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      imem_req_q  <= imem_req_d;
      valid_q     <= valid_d;
      opcode_q    <= opcode_d;
      payload_q   <= payload_d;
      halted_q    <= halted_d;
      fetch_err_q <= fetch_err_d;
      tmo_q       <= tmo_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    imem_req_d  = imem_req_q;
    valid_d     = valid_q;
    opcode_d    = opcode_q;
    payload_d   = payload_q;
    halted_d    = halted_q;
    fetch_err_d = fetch_err_q;
    tmo_d       = tmo_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d    = ST_FETCH;
          imem_req_d = 1'b1;
          tmo_d      = '0;
        end
      end

      ST_FETCH: begin
        // Ack wins over timeout when both land on the last allowed cycle
        if (bus.imem_ack) begin
          state_d    = ST_ISSUE;
          imem_req_d = 1'b0;
          valid_d    = 1'b1;
          opcode_d   = bus.imem_rdata[INSTR_W-1 -: 5];
          payload_d  = bus.imem_rdata[PAYLOAD_W-1:0];
        end else if (tmo_q == CNT_W'(TIMEOUT - 1)) begin
          state_d     = ST_HALT;
          imem_req_d  = 1'b0;
          fetch_err_d = 1'b1;
          halted_d    = 1'b1;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end

      ST_ISSUE: begin
        if (valid_q && bus.instr_ready) begin
          valid_d = 1'b0;
          if (opcode_q == HALT_OP) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else begin
            state_d    = ST_FETCH;
            imem_req_d = 1'b1;
            tmo_d      = '0;
            pc_d       = bus.branch_en ? bus.branch_target : pc_q + ADDR_W'(1);
          end
        end
      end

      ST_HALT: begin
        if (start_i) begin
          state_d     = ST_FETCH;
          pc_d        = '0;
          halted_d    = 1'b0;
          fetch_err_d = 1'b0;
          imem_req_d  = 1'b1;
          tmo_d       = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.opcode      = opcode_q;
  assign bus.payload     = payload_q;
  assign bus.instr_valid = valid_q;
  assign pc_o            = pc_q;
  assign halted_o        = halted_q;
  assign fetch_err_o     = fetch_err_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: fetch/issue, stall, branch, wrap,
// timeout fault and recovery, HALT opcode, reset during ISSUE.
module tb_fetch_unit;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] pc;
  logic       halted;
  logic       fetch_err;

  int tests  = 0;
  int failed = 0;

  fetch_unit_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

  fetch_unit #(.ADDR_W(8), .INSTR_W(16), .TIMEOUT(16), .HALT_OP(5'b11111)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .bus         (bus),
    .pc_o        (pc),
    .halted_o    (halted),
    .fetch_err_o (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // From FETCH: ack with word, then handshake with given branch inputs
  task automatic fetch_issue(input logic [15:0] word, input logic br, input logic [7:0] tgt);
    bus.imem_ack = 1'b1; bus.imem_rdata = word;
    tick();
    bus.imem_ack = 1'b0;
    bus.instr_ready = 1'b1; bus.branch_en = br; bus.branch_target = tgt;
    tick();
    bus.instr_ready = 1'b0; bus.branch_en = 1'b0; bus.branch_target = 8'h00;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 16'h0000;
    bus.instr_ready = 1'b0; bus.branch_en = 1'b0; bus.branch_target = 8'h00;
    tick(); tick();
    chk("rst_req",    32'(bus.imem_req),    32'd0);
    chk("rst_valid",  32'(bus.instr_valid), 32'd0);
    chk("rst_opcode", 32'(bus.opcode),      32'd0);
    chk("rst_payload",32'(bus.payload),     32'd0);
    chk("rst_pc",     32'(pc),              32'd0);
    chk("rst_halted", 32'(halted),          32'd0);
    chk("rst_err",    32'(fetch_err),       32'd0);
    rst_n = 1'b1;

    // Start, ack after 2 fetch cycles with 16'h1234
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("fetch_req",  32'(bus.imem_req),  32'd1);
    chk("fetch_addr", 32'(bus.imem_addr), 32'd0);
    tick();
    chk("fetch_req_hold", 32'(bus.imem_req), 32'd1);
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'h1234;
    tick();
    bus.imem_ack = 1'b0;
    chk("issue_valid",   32'(bus.instr_valid), 32'd1);
    chk("issue_opcode",  32'(bus.opcode),      32'h02);
    chk("issue_payload", 32'(bus.payload),     32'h234);
    chk("issue_req",     32'(bus.imem_req),    32'd0);

    // Stall 5 cycles; stray ack/branch/start must be ignored
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'hFFFF;
    bus.branch_en = 1'b1; bus.branch_target = 8'h55; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid",   32'(bus.instr_valid), 32'd1);
      chk("stall_opcode",  32'(bus.opcode),      32'h02);
      chk("stall_payload", 32'(bus.payload),     32'h234);
      chk("stall_req",     32'(bus.imem_req),    32'd0);
    end
    bus.imem_ack = 1'b0; bus.branch_en = 1'b0; bus.branch_target = 8'h00; start = 1'b0;
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    chk("next_addr",  32'(bus.imem_addr),   32'd1);
    chk("next_req",   32'(bus.imem_req),    32'd1);
    chk("next_valid", 32'(bus.instr_valid), 32'd0);

    // Branch to F0, then to FF, then sequential wrap to 00
    fetch_issue(16'h0855, 1'b1, 8'hF0);
    chk("branch_addr", 32'(bus.imem_addr), 32'hF0);
    fetch_issue(16'h0855, 1'b1, 8'hFF);
    chk("branch_ff",   32'(bus.imem_addr), 32'hFF);
    fetch_issue(16'h0855, 1'b0, 8'h00);
    chk("wrap_addr",   32'(bus.imem_addr), 32'h00);
    chk("wrap_req",    32'(bus.imem_req),  32'd1);
    fetch_issue(16'h0855, 1'b0, 8'h00);
    chk("pc_one",      32'(pc),            32'd1);

    // Timeout: 16 fetch cycles without ack
    for (int i = 0; i < 15; i++) tick();
    chk("tmo_req_last", 32'(bus.imem_req),  32'd1);
    chk("tmo_err_last", 32'(fetch_err),     32'd0);
    chk("tmo_addr",     32'(bus.imem_addr), 32'd1);
    tick();
    chk("tmo_req",    32'(bus.imem_req), 32'd0);
    chk("tmo_err",    32'(fetch_err),    32'd1);
    chk("tmo_halted", 32'(halted),       32'd1);
    bus.imem_ack = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    chk("halt_ack_valid", 32'(bus.instr_valid), 32'd0);
    chk("halt_ack_err",   32'(fetch_err),       32'd1);

    // Restart from HALT
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_pc",     32'(pc),           32'd0);
    chk("restart_err",    32'(fetch_err),    32'd0);
    chk("restart_halted", 32'(halted),       32'd0);
    chk("restart_req",    32'(bus.imem_req), 32'd1);

    // Ack on the last allowed cycle counts as success
    for (int i = 0; i < 15; i++) tick();
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'h1234;
    tick();
    bus.imem_ack = 1'b0;
    chk("late_valid",  32'(bus.instr_valid), 32'd1);
    chk("late_err",    32'(fetch_err),       32'd0);
    chk("late_halted", 32'(halted),          32'd0);
    chk("late_req",    32'(bus.imem_req),    32'd0);
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    chk("late_next_addr", 32'(bus.imem_addr), 32'd1);

    // HALT opcode
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'hF800;
    tick();
    bus.imem_ack = 1'b0;
    chk("haltop_opcode", 32'(bus.opcode), 32'h1F);
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    chk("haltop_halted", 32'(halted),          32'd1);
    chk("haltop_valid",  32'(bus.instr_valid), 32'd0);
    chk("haltop_pc",     32'(pc),              32'd1);
    chk("haltop_err",    32'(fetch_err),       32'd0);
    tick(); tick();
    chk("haltop_noreq",  32'(bus.imem_req),    32'd0);

    // Reset during ISSUE
    start = 1'b1;
    tick();
    start = 1'b0;
    fetch_issue(16'h0855, 1'b0, 8'h00);
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'hABCD;
    tick();
    bus.imem_ack = 1'b0;
    chk("pre_rst_valid",  32'(bus.instr_valid), 32'd1);
    chk("pre_rst_opcode", 32'(bus.opcode),      32'h15);
    chk("pre_rst_pc",     32'(pc),              32'd1);
    rst_n = 1'b0; bus.instr_ready = 1'b1; start = 1'b1;
    tick();
    chk("mid_rst_valid",   32'(bus.instr_valid), 32'd0);
    chk("mid_rst_opcode",  32'(bus.opcode),      32'd0);
    chk("mid_rst_payload", 32'(bus.payload),     32'd0);
    chk("mid_rst_pc",      32'(pc),              32'd0);
    chk("mid_rst_req",     32'(bus.imem_req),    32'd0);
    chk("mid_rst_halted",  32'(halted),          32'd0);
    rst_n = 1'b1; bus.instr_ready = 1'b0; start = 1'b0;
    tick();
    chk("idle_noreq", 32'(bus.imem_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
